// File: rtl/dk_mixer_pkg.sv
// Shared constants and state encoding for the discrete-sound mixer datapath.
package dk_mixer_pkg;

  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned GAIN_W         = 8;
  localparam int unsigned PROD_W         = 25;
  localparam int unsigned GAIN_FRAC_BITS = 6;
  localparam int unsigned ACC_WIDTH      = 32;

  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SAT
  } mixer_state_t;

endpackage

// File: rtl/sat_clip16.sv
// Combinational saturation of a wide signed value to 16 bits, flagging any clip.
module sat_clip16
  import dk_mixer_pkg::*;
(
  input  logic signed [ACC_WIDTH-1:0] din,
  output logic signed [15:0]          dout_c,
  output logic                        clip_c
);

  always_comb begin
    dout_c = din[15:0];
    clip_c = 1'b0;
    if (din > $signed(ACC_WIDTH'(SAMPLE_MAX))) begin
      dout_c = 16'(SAMPLE_MAX);
      clip_c = 1'b1;
    end else if (din < $signed(ACC_WIDTH'(SAMPLE_MIN))) begin
      dout_c = 16'(SAMPLE_MIN);
      clip_c = 1'b1;
    end
  end

endmodule

// File: rtl/dk_sound_mixer.sv
// Time-multiplexed gain-and-sum of the discrete sound generators: snapshot on the
// sample tick, one shared multiply-accumulate per channel, then saturate to 16 bits.
module dk_sound_mixer
  import dk_mixer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CLOCK_RATE   = 1000000,
  parameter int unsigned SAMPLE_RATE  = 48000
) (
  input  logic                       clk,
  input  logic                       I_RSTn,
  input  logic                       audio_clk_en,
  input  logic signed [SAMPLE_W-1:0] in_sample [NUM_CHANNELS],
  input  logic        [GAIN_W-1:0]   gain      [NUM_CHANNELS],
  input  logic                       clear_flags,
  output logic signed [SAMPLE_W-1:0] out,
  output logic                       out_valid,
  output logic                       clipped,
  output logic                       overrun
);

  localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  // The whole sample must finish before the next tick can arrive.
  if ((NUM_CHANNELS < 1) || (NUM_CHANNELS > 8) ||
      ((CLOCK_RATE / SAMPLE_RATE) < (NUM_CHANNELS + 2))) begin : g_cfg_check
    $error("dk_sound_mixer: invalid NUM_CHANNELS / clock-to-sample ratio");
  end

  mixer_state_t                state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic        [IDX_W-1:0]     idx_q, idx_d;
  logic                        snap_en;
  logic signed [SAMPLE_W-1:0]  snap_sample [NUM_CHANNELS];
  logic        [GAIN_W-1:0]    snap_gain   [NUM_CHANNELS];

  logic signed [SAMPLE_W-1:0]  out_d;
  logic                        out_valid_d, clipped_d, overrun_d;

  logic signed [PROD_W-1:0]    sample_ext_c, gain_ext_c, prod_c;
  logic signed [ACC_WIDTH-1:0] shifted_c;
  logic signed [15:0]          sat_out_c;
  logic                        sat_clip_c;

  // Single shared multiplier; gain is unsigned so it is zero-extended before the signed multiply.
  assign sample_ext_c = PROD_W'(snap_sample[idx_q]);
  assign gain_ext_c   = $signed(PROD_W'({1'b0, snap_gain[idx_q]}));
  assign prod_c       = sample_ext_c * gain_ext_c;
  assign shifted_c    = acc_q >>> GAIN_FRAC_BITS;

  sat_clip16 u_sat (
    .din    (shifted_c),
    .dout_c (sat_out_c),
    .clip_c (sat_clip_c)
  );

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    snap_en     = 1'b0;
    out_d       = out;
    out_valid_d = 1'b0;
    clipped_d   = clear_flags ? 1'b0 : clipped;
    overrun_d   = clear_flags ? 1'b0 : overrun;

    case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          snap_en = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_WIDTH'(prod_c);
        if (idx_q == LAST_IDX) state_d = SAT;
        else                   idx_d   = IDX_W'(idx_q + 1'b1);
      end
      SAT: begin
        out_d       = sat_out_c;
        out_valid_d = 1'b1;
        if (sat_clip_c) clipped_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ticks during a computation are dropped, not queued.
    if (audio_clk_en && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      acc_q     <= '0;
      idx_q     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      clipped   <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        snap_sample[i] <= '0;
        snap_gain[i]   <= '0;
      end
    end else begin
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      clipped   <= clipped_d;
      overrun   <= overrun_d;
      if (snap_en) begin
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
          snap_sample[i] <= in_sample[i];
          snap_gain[i]   <= gain[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_dk_sound_mixer.sv
// Directed self-checking bench for dk_sound_mixer with hand-computed expected samples.
module tb_dk_sound_mixer;

  localparam int unsigned NCH = 4;

  logic               clk = 1'b0;
  logic               I_RSTn;
  logic               audio_clk_en;
  logic signed [15:0] in_sample [NCH];
  logic        [7:0]  gain      [NCH];
  logic               clear_flags;
  logic signed [15:0] out;
  logic               out_valid;
  logic               clipped;
  logic               overrun;

  int checks   = 0;
  int failures = 0;

  dk_sound_mixer #(
    .NUM_CHANNELS (NCH),
    .CLOCK_RATE   (1000000),
    .SAMPLE_RATE  (48000)
  ) dut (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .in_sample    (in_sample),
    .gain         (gain),
    .clear_flags  (clear_flags),
    .out          (out),
    .out_valid    (out_valid),
    .clipped      (clipped),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Tick for one cycle, then count cycles until out_valid (bounded); -1 on timeout.
  task automatic run_sample(output int lat);
    bit seen;
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    lat  = -1;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!seen) begin
        step();
        if (out_valid) begin
          lat  = k;
          seen = 1'b1;
        end
      end
    end
  endtask

  task automatic set_all(input logic signed [15:0] s, input logic [7:0] g);
    for (int i = 0; i < int'(NCH); i++) begin
      in_sample[i] = s;
      gain[i]      = g;
    end
  endtask

  int lat;
  int nvalid;
  int first_k;
  int held;

  initial begin
    I_RSTn       = 1'b0;
    audio_clk_en = 1'b0;
    clear_flags  = 1'b0;
    set_all(16'sd0, 8'd0);
    step();
    step();
    chk("rst_out", int'(out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_clipped", int'(clipped), 0);
    chk("rst_overrun", int'(overrun), 0);
    I_RSTn = 1'b1;
    step();

    // Unity gain on a single channel
    set_all(16'sd777, 8'd0);
    in_sample[0] = 16'sd6826;
    gain[0]      = 8'd64;
    run_sample(lat);
    chk("unity_latency", lat, 5);
    chk("unity_out", int'(out), 6826);
    chk("unity_clipped", int'(clipped), 0);
    step();
    chk("unity_pulse_width", int'(out_valid), 0);
    step();
    step();
    chk("unity_out_held", int'(out), 6826);

    // Weighted sum of four channels
    in_sample[0] = 16'sd1000;   gain[0] = 8'd64;
    in_sample[1] = -16'sd2000;  gain[1] = 8'd32;
    in_sample[2] = 16'sd4000;   gain[2] = 8'd16;
    in_sample[3] = 16'sd100;    gain[3] = 8'd128;
    run_sample(lat);
    chk("weighted_latency", lat, 5);
    chk("weighted_out", int'(out), 1200);

    // Reset in the middle of the MAC phase
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    step();
    step();
    I_RSTn = 1'b0;
    #1;
    chk("midrst_out", int'(out), 0);
    chk("midrst_valid", int'(out_valid), 0);
    step();
    I_RSTn = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid) nvalid++;
    end
    chk("midrst_no_valid", nvalid, 0);
    chk("midrst_out_after", int'(out), 0);

    // Positive and negative saturation, then clear the sticky flag
    set_all(16'sd30000, 8'd255);
    run_sample(lat);
    chk("satpos_latency", lat, 5);
    chk("satpos_out", int'(out), 32767);
    chk("satpos_clipped", int'(clipped), 1);
    set_all(-16'sd30000, 8'd255);
    run_sample(lat);
    chk("satneg_out", int'(out), -32768);
    chk("satneg_clipped", int'(clipped), 1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("clear_clipped", int'(clipped), 0);
    chk("no_overrun_yet", int'(overrun), 0);

    // Second tick two cycles after the first is dropped
    set_all(16'sd500, 8'd0);
    in_sample[0] = 16'sd1000;
    gain[0]      = 8'd64;
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    step();
    audio_clk_en = 1'b1;
    in_sample[0] = 16'sd5000;
    step();
    audio_clk_en = 1'b0;
    nvalid  = 0;
    first_k = -1;
    held    = 0;
    for (int k = 3; k <= 15; k++) begin
      step();
      if (out_valid) begin
        nvalid++;
        if (first_k < 0) begin
          first_k = k;
          held    = int'(out);
        end
      end
    end
    chk("overrun_valid_count", nvalid, 1);
    chk("overrun_valid_at", first_k, 5);
    chk("overrun_out", held, 1000);
    chk("overrun_flag", int'(overrun), 1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("clear_overrun", int'(overrun), 0);

    // Input change after the tick must not leak into the sample
    in_sample[0] = 16'sd1000;
    audio_clk_en = 1'b1;
    step();
    audio_clk_en = 1'b0;
    in_sample[0] = 16'sd9000;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (lat < 0) begin
        step();
        if (out_valid) lat = k;
      end
    end
    chk("snapshot_latency", lat, 5);
    chk("snapshot_out", int'(out), 1000);
    chk("snapshot_overrun", int'(overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
